nanorv32_periph_timer: RTL

Memory-mapped 32-bit timer/compare peripheral for the nanorv32 chip. It sits downstream of the chip-level address decoder and serves CPU load/store accesses that decode to the peripheral space (address bits [31:28] = 4'hF). It returns read data and an acknowledge that feed the peripheral read-data path of the data-port mux, and it raises a level interrupt on compare match. It provides a prescaled free-running or auto-reload counter.

---
 rtl/nanorv32_periph_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nanorv32_periph_timer.sv
// Memory-mapped timer/compare peripheral: prescaled 32-bit counter with
// compare-match flag, optional auto-reload and a level interrupt.
module nanorv32_periph_timer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              periph_req,
    input  logic [ADDR_W-1:0] periph_addr,
    input  logic [3:0]        periph_bytesel,
    input  logic [31:0]       periph_wdata,
    output logic [31:0]       periph_rdata,
    output logic              periph_ack,
    output logic              timer_irq
);

    localparam logic [2:0] R_CTRL     = 3'd0;
    localparam logic [2:0] R_STATUS   = 3'd1;
    localparam logic [2:0] R_PRESCALE = 3'd2;
    localparam logic [2:0] R_COUNT    = 3'd3;
    localparam logic [2:0] R_COMPARE  = 3'd4;

    logic [2:0]  ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ack_r_q, ack_r_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  sel;
    logic        wr_en, rd_acc, tick, hit;
    logic [31:0] rd_val, ctrl_m, pre_m;
    logic        unused_addr;

    assign sel         = periph_addr[4:2];
    assign unused_addr = ^periph_addr;
    assign wr_en       = periph_req & (|periph_bytesel);
    // A read is not re-accepted in its own ack cycle, so a held read acks every other cycle.
    assign rd_acc      = periph_req & ~(|periph_bytesel) & ~ack_r_q;
    assign tick        = ctrl_q[0] & (pcnt_q == prescale_q);
    assign hit         = tick & (count_q == compare_q);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        case (sel)
            R_CTRL:     rd_val = {29'd0, ctrl_q};
            R_STATUS:   rd_val = {31'd0, match_q};
            R_PRESCALE: rd_val = {16'd0, prescale_q};
            R_COUNT:    rd_val = count_q;
            R_COMPARE:  rd_val = compare_q;
            default:    rd_val = 32'd0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        match_d    = match_q | hit;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        ctrl_m     = 32'd0;
        pre_m      = 32'd0;
        pcnt_d     = (!ctrl_q[0] || tick) ? 16'd0 : pcnt_q + 16'd1;
        count_d    = count_q;
        if (tick)
            count_d = (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;

        // CPU writes override the tick result byte by byte; a same-cycle match beats W1C.
        if (wr_en) begin
            case (sel)
                R_CTRL: begin
                    ctrl_m = merge({29'd0, ctrl_q}, periph_wdata, periph_bytesel);
                    ctrl_d = ctrl_m[2:0];
                end
                R_STATUS: if (periph_bytesel[0] && periph_wdata[0] && !hit) match_d = 1'b0;
                R_PRESCALE: begin
                    pre_m      = merge({16'd0, prescale_q}, periph_wdata, periph_bytesel);
                    prescale_d = pre_m[15:0];
                    pcnt_d     = 16'd0;
                end
                R_COUNT:   count_d   = merge(count_d, periph_wdata, periph_bytesel);
                R_COMPARE: compare_d = merge(compare_q, periph_wdata, periph_bytesel);
                default: ;
            endcase
        end

        ack_r_d = rd_acc;
        rdata_d = rd_acc ? rd_val : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= 3'd0;
            match_q    <= 1'b0;
            prescale_q <= 16'd0;
            pcnt_q     <= 16'd0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            ack_r_q    <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            ack_r_q    <= ack_r_d;
            rdata_q    <= rdata_d;
        end
    end

    assign periph_ack   = wr_en | ack_r_q;
    assign periph_rdata = rdata_q;
    assign timer_irq    = match_q & ctrl_q[2];

endmodule
